// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: machine width, bubble encoding and the
// fetch FSM state type.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits are cleared.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Request/response bus between the fetch stage (master) and instruction
// memory (slave).
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter register: a redirect loads the aligned target and takes
// priority over the sequential +4 advance.
module if_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic        advance,
  input  logic [31:0] target,
  output logic [31:0] pc
);
  import if_fetch_unit_pkg::*;

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  // Next-PC selection; the +4 wraps naturally at the top of the address space.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = align_word(target);
    end else if (advance) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: single-outstanding memory handshake, instruction
// holding register and branch/jump redirect handling.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_write,
  input  logic                 pc_src,
  input  logic [31:0]          branch_target,
  if_fetch_unit_if.master      imem,
  output logic [31:0]          pc_out,
  output logic [31:0]          instruction_out,
  output logic                 if_valid
);
  import if_fetch_unit_pkg::fetch_state_e;
  import if_fetch_unit_pkg::FETCH;
  import if_fetch_unit_pkg::WAIT;
  import if_fetch_unit_pkg::HOLD;
  import if_fetch_unit_pkg::DROP;

  fetch_state_e state_d;
  fetch_state_e state_q;
  logic [31:0]  inst_d;
  logic [31:0]  inst_q;
  logic         pc_advance_s;
  logic         req_s;
  logic         grant_s;
  logic [31:0]  pc_s;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .redirect (pc_src),
    .advance  (pc_advance_s),
    .target   (branch_target),
    .pc       (pc_s)
  );

  assign req_s   = (state_q == FETCH) && !reset;
  assign grant_s = req_s && imem.imem_gnt;

  // Next-state and holding-register logic; a redirect squashes whatever is in flight.
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    pc_advance_s = 1'b0;
    case (state_q)
      FETCH: begin
        if (grant_s) begin
          state_d = pc_src ? DROP : WAIT;
        end else begin
          state_d = FETCH;
        end
      end
      WAIT: begin
        if (pc_src) begin
          state_d = imem.imem_rvalid ? FETCH : DROP;
        end else if (imem.imem_rvalid) begin
          inst_d  = imem.imem_rdata;
          state_d = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (pc_src) begin
          state_d = FETCH;
        end else if (pc_write) begin
          pc_advance_s = 1'b1;
          state_d      = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        if (imem.imem_rvalid) begin
          state_d = FETCH;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // FSM state and held instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      inst_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
    end
  end

  assign imem.imem_req   = req_s;
  assign imem.imem_addr  = pc_s;
  assign pc_out          = pc_s;
  assign if_valid        = (state_q == HOLD);
  assign instruction_out = if_valid ? inst_q : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory responses are driven step by step,
// instructions meant to reach the pipeline are queued and checked on consumption.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        pc_src;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        if_valid;

  int total;
  int bad;
  exp_t sb_q[$];

  if_fetch_unit_if imem_bus ();

  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pc_write        (pc_write),
    .pc_src          (pc_src),
    .branch_target   (branch_target),
    .imem            (imem_bus.master),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .if_valid        (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Grant a request at addr and return data one cycle later; optionally queue it.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input bit keep);
    chk("fetch_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("fetch_addr", imem_bus.imem_addr, addr);
    if (keep) sb_q.push_back('{pc: addr, instr: data});
    imem_bus.imem_gnt = 1'b1;
    tick();
    imem_bus.imem_gnt = 1'b0;
    chk("wait_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = data;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
  endtask

  // Pipeline accepts the held instruction; compare against the queue head.
  task automatic consume();
    exp_t e;
    chk("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("hold_valid", {31'd0, if_valid}, 32'd1);
      chk("hold_pc", pc_out, e.pc);
      chk("hold_instr", instruction_out, e.instr);
    end
    pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    pc_write = 1'b0;
    pc_src = 1'b0;
    branch_target = 32'h0;
    imem_bus.imem_gnt = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata = 32'h0;

    tick();
    tick();
    chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", pc_out, 32'h0000_0000);
    chk("rst_instr", instruction_out, NOP);
    reset = 1'b0;
    #1;

    // Basic fetch and consume.
    fetch(32'h0, 32'h0050_0093, 1'b1);
    consume();
    chk("next_addr4", imem_bus.imem_addr, 32'h4);
    chk("fetch_invalid", {31'd0, if_valid}, 32'd0);

    // Stall in HOLD for four cycles.
    fetch(32'h4, 32'h1111_1111, 1'b1);
    consume();
    fetch(32'h8, 32'h2222_2222, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_instr", instruction_out, 32'h2222_2222);
      chk("stall_req", {31'd0, imem_bus.imem_req}, 32'd0);
    end
    consume();
    chk("after_stall_addr", imem_bus.imem_addr, 32'hC);

    // Redirect in WAIT, response arrives two cycles later and is discarded.
    imem_bus.imem_gnt = 1'b1;
    tick();
    imem_bus.imem_gnt = 1'b0;
    pc_src = 1'b1;
    branch_target = 32'h100;
    tick();
    pc_src = 1'b0;
    chk("drop_valid", {31'd0, if_valid}, 32'd0);
    chk("drop_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("drop_addr", imem_bus.imem_addr, 32'h100);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    chk("dropped_valid", {31'd0, if_valid}, 32'd0);
    chk("dropped_instr", instruction_out, NOP);

    // Redirect to unaligned target together with rvalid in WAIT.
    imem_bus.imem_gnt = 1'b1;
    chk("redir_addr_100", imem_bus.imem_addr, 32'h100);
    tick();
    imem_bus.imem_gnt = 1'b0;
    pc_src = 1'b1;
    branch_target = 32'h203;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h3333_3333;
    tick();
    pc_src = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    chk("wr_valid", {31'd0, if_valid}, 32'd0);
    chk("wr_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("wr_addr", imem_bus.imem_addr, 32'h200);

    // Redirect while stalled in HOLD discards the held instruction.
    fetch(32'h200, 32'h4444_4444, 1'b0);
    chk("hold2_valid", {31'd0, if_valid}, 32'd1);
    chk("hold2_instr", instruction_out, 32'h4444_4444);
    pc_src = 1'b1;
    branch_target = 32'h300;
    tick();
    pc_src = 1'b0;
    chk("hr_instr", instruction_out, NOP);
    chk("hr_valid", {31'd0, if_valid}, 32'd0);
    chk("hr_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("hr_addr", imem_bus.imem_addr, 32'h300);

    // Grant withheld for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nogrant_req", {31'd0, imem_bus.imem_req}, 32'd1);
      chk("nogrant_addr", imem_bus.imem_addr, 32'h300);
    end

    // PC wrap from the top of the address space.
    pc_src = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    pc_src = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h5555_5555, 1'b1);
    consume();
    chk("wrap_addr", imem_bus.imem_addr, 32'h0);

    // Redirect in FETCH on the grant cycle, then re-redirect while in DROP.
    imem_bus.imem_gnt = 1'b1;
    pc_src = 1'b1;
    branch_target = 32'h40;
    tick();
    imem_bus.imem_gnt = 1'b0;
    chk("fd_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("fd_addr", imem_bus.imem_addr, 32'h40);
    branch_target = 32'h80;
    tick();
    pc_src = 1'b0;
    chk("dd_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("dd_addr", imem_bus.imem_addr, 32'h80);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h6666_6666;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    chk("dr_valid", {31'd0, if_valid}, 32'd0);
    chk("dr_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("dr_addr", imem_bus.imem_addr, 32'h80);

    // Reset with a request outstanding; the late response is ignored.
    imem_bus.imem_gnt = 1'b1;
    tick();
    imem_bus.imem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    chk("mrst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("mrst_pc", pc_out, 32'h0);
    reset = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h7777_7777;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    chk("stray_valid", {31'd0, if_valid}, 32'd0);
    chk("stray_req", {31'd0, imem_bus.imem_req}, 32'd1);
    fetch(32'h0, 32'h0010_0113, 1'b1);
    consume();
    chk("final_addr", imem_bus.imem_addr, 32'h4);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
